// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory stage: op codes, bus widths,
// byte-enable patterns, LSU state encoding and op classification helpers.
package mem_lsu_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_ADDR_W = 5;

    // EX stage op codes (subset relevant to the memory stage)
    localparam logic [ALU_OP_W-1:0] EX_NOP_OP = 8'h00;
    localparam logic [ALU_OP_W-1:0] EX_ADD_OP = 8'h01;
    localparam logic [ALU_OP_W-1:0] EX_SUB_OP = 8'h02;
    localparam logic [ALU_OP_W-1:0] EX_AND_OP = 8'h03;
    localparam logic [ALU_OP_W-1:0] EX_OR_OP  = 8'h04;
    localparam logic [ALU_OP_W-1:0] EX_LB_OP  = 8'h10;
    localparam logic [ALU_OP_W-1:0] EX_LH_OP  = 8'h11;
    localparam logic [ALU_OP_W-1:0] EX_LW_OP  = 8'h12;
    localparam logic [ALU_OP_W-1:0] EX_LBU_OP = 8'h13;
    localparam logic [ALU_OP_W-1:0] EX_LHU_OP = 8'h14;
    localparam logic [ALU_OP_W-1:0] EX_SB_OP  = 8'h18;
    localparam logic [ALU_OP_W-1:0] EX_SH_OP  = 8'h19;
    localparam logic [ALU_OP_W-1:0] EX_SW_OP  = 8'h1A;

    // Byte-enable base patterns, shifted into place by the byte offset
    localparam logic [3:0] MEM_BE_NONE = 4'b0000;
    localparam logic [3:0] MEM_BE_BYTE = 4'b0001;
    localparam logic [3:0] MEM_BE_HALF = 4'b0011;
    localparam logic [3:0] MEM_BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
        return (op == EX_LB_OP) || (op == EX_LH_OP) || (op == EX_LW_OP) ||
               (op == EX_LBU_OP) || (op == EX_LHU_OP);
    endfunction

    function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
        return (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
    endfunction

    function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_half_op(input logic [ALU_OP_W-1:0] op);
        return (op == EX_LH_OP) || (op == EX_LHU_OP) || (op == EX_SH_OP);
    endfunction

    function automatic logic is_word_op(input logic [ALU_OP_W-1:0] op);
        return (op == EX_LW_OP) || (op == EX_SW_OP);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane handling: store byte-enable/data replication and
// alignment check for the incoming op, load lane extraction and extension
// for the op latched when the transaction was accepted.
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] st_op,
    input  logic [1:0]          st_off,
    input  logic [31:0]         st_data,
    output logic [3:0]          be,
    output logic [31:0]         wdata,
    output logic                misalign,
    input  logic [ALU_OP_W-1:0] ld_op,
    input  logic [1:0]          ld_off,
    input  logic [31:0]         rdata,
    output logic [31:0]         ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lanes, byte enables (loads read the full word) and alignment check
    always_comb begin
        be       = MEM_BE_WORD;
        wdata    = '0;
        misalign = 1'b0;
        case (st_op)
            EX_SB_OP: begin
                be    = MEM_BE_BYTE << st_off;
                wdata = {4{st_data[7:0]}};
            end
            EX_SH_OP: begin
                be    = MEM_BE_HALF << {st_off[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            EX_SW_OP: wdata = st_data;
            default: ;
        endcase
        if (is_half_op(st_op)) begin
            misalign = st_off[0];
        end else if (is_word_op(st_op)) begin
            misalign = |st_off;
        end
    end

    // Load lane select and sign/zero extension
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            EX_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EX_LBU_OP: ld_data = {24'h0, ld_byte};
            EX_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EX_LHU_OP: ld_data = {16'h0, ld_half};
            default:   ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one request/grant/response bus
// transaction per aligned load or store, stalls the pipeline while it is
// outstanding, and drives the MEM/WB writeback registers.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    input  logic [31:0]           w_data_i,
    output logic                  stall_req_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [31:0]           dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [31:0]           dbus_wdata_o,
    input  logic                  dbus_gnt_i,
    input  logic                  dbus_rvalid_i,
    input  logic [31:0]           dbus_rdata_i,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [31:0]           w_data_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    lsu_state_e            state, state_nx;
    logic [31:0]           tmo_cnt;
    logic [ALU_OP_W-1:0]   op_q;
    logic [1:0]            off_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] waddr_q;

    logic [3:0]            st_be;
    logic [31:0]           st_wdata;
    logic [31:0]           ld_data;
    logic                  misalign;
    logic                  mem_op;
    logic                  accept;
    logic                  resp;
    logic                  timeout;

    mem_align u_align (
        .st_op    (aluop_i),
        .st_off   (mem_addr_i[1:0]),
        .st_data  (w_data_i),
        .be       (st_be),
        .wdata    (st_wdata),
        .misalign (misalign),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .rdata    (dbus_rdata_i),
        .ld_data  (ld_data)
    );

    assign mem_op     = valid_i && is_mem_op(aluop_i);
    assign dbus_req_o = (state == LSU_REQ);

    // Next state, handshake events and stall request
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        resp        = 1'b0;
        timeout     = 1'b0;
        stall_req_o = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (mem_op && !misalign) begin
                    accept      = 1'b1;
                    stall_req_o = 1'b1;
                    state_nx    = LSU_REQ;
                end
            end
            LSU_REQ: begin
                stall_req_o = 1'b1;
                if (dbus_gnt_i) begin
                    state_nx = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dbus_rvalid_i) begin
                    resp     = 1'b1;
                    state_nx = LSU_IDLE;
                end else begin
                    stall_req_o = 1'b1;
                    if ((RESP_TIMEOUT != 0) && (tmo_cnt + 32'd1 == RESP_TIMEOUT)) begin
                        timeout  = 1'b1;
                        state_nx = LSU_IDLE;
                    end
                end
            end
            default: state_nx = LSU_IDLE;
        endcase
    end

    // State register and WAIT-cycle timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LSU_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == LSU_WAIT && state_nx == LSU_WAIT) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Bus request registers, latched transaction context and writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            op_q         <= '0;
            off_q        <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            w_enable_o   <= 1'b0;
            w_addr_o     <= '0;
            w_data_o     <= '0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            w_enable_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (state == LSU_IDLE && valid_i && !is_mem_op(aluop_i)) begin
                w_enable_o <= w_enable_i && (w_addr_i != '0);
                w_addr_o   <= w_addr_i;
                w_data_o   <= w_data_i;
            end
            if (state == LSU_IDLE && mem_op && misalign) begin
                misalign_o <= 1'b1;
            end
            if (accept) begin
                dbus_we_o    <= is_store(aluop_i);
                dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                dbus_be_o    <= st_be;
                dbus_wdata_o <= st_wdata;
                op_q         <= aluop_i;
                off_q        <= mem_addr_i[1:0];
                wen_q        <= w_enable_i && (w_addr_i != '0);
                waddr_q      <= w_addr_i;
            end
            if (resp && is_load(op_q)) begin
                w_enable_o <= wen_q;
                w_addr_o   <= waddr_q;
                w_data_o   <= ld_data;
            end
            if (timeout) begin
                bus_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  valid_i;
    logic [ALU_OP_W-1:0]   aluop_i;
    logic [31:0]           mem_addr_i;
    logic                  w_enable_i;
    logic [REG_ADDR_W-1:0] w_addr_i;
    logic [31:0]           w_data_i;
    logic                  stall_req_o;
    logic                  dbus_req_o;
    logic                  dbus_we_o;
    logic [31:0]           dbus_addr_o;
    logic [3:0]            dbus_be_o;
    logic [31:0]           dbus_wdata_o;
    logic                  dbus_gnt_i;
    logic                  dbus_rvalid_i;
    logic [31:0]           dbus_rdata_i;
    logic                  w_enable_o;
    logic [REG_ADDR_W-1:0] w_addr_o;
    logic [31:0]           w_data_o;
    logic                  misalign_o;
    logic                  bus_err_o;

    always #5 clk = ~clk;

    mem_lsu #(.RESP_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .aluop_i       (aluop_i),
        .mem_addr_i    (mem_addr_i),
        .w_enable_i    (w_enable_i),
        .w_addr_i      (w_addr_i),
        .w_data_i      (w_data_i),
        .stall_req_o   (stall_req_o),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_gnt_i    (dbus_gnt_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .w_enable_o    (w_enable_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o)
    );

    // kind: 0 = ALU op, 1 = aligned memory op, 2 = misaligned memory op
    typedef struct {
        int          kind;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        wen;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
    } wb_t;

    localparam int NV = 19;
    vec_t vt [NV];
    wb_t  sb_q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic outs_nonzero();
        return |{stall_req_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
                 w_enable_o, w_addr_o, w_data_o, misalign_o, bus_err_o};
    endfunction

    task automatic check_wb();
        wb_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e = sb_q.pop_front();
            chk("wb_enable", w_enable_o, e.wen);
            if (e.wen) begin
                chk("wb_addr", w_addr_o, e.waddr);
                chk("wb_data", w_data_o, e.wdata);
            end
            chk("misalign", misalign_o, e.mis);
            chk("bus_err", bus_err_o, e.err);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i    = 1'b1;
        aluop_i    = v.op;
        mem_addr_i = v.addr;
        w_enable_i = 1'b1;
        w_addr_i   = v.waddr;
        w_data_i   = v.data;
    endtask

    // ALU or misaligned op: retires one cycle after acceptance, no stall, no bus
    task automatic run_simple(input vec_t v);
        sb_q.push_back('{v.wen, v.waddr, v.wdata, (v.kind == 2), 1'b0});
        drive(v);
        #1;
        chk("stall_simple", stall_req_o, 0);
        chk("req_simple", dbus_req_o, 0);
        step();
        valid_i = 1'b0;
        check_wb();
        chk("req_after_simple", dbus_req_o, 0);
    endtask

    // Aligned memory op with gdly cycles before gnt and rdly cycles before rvalid
    task automatic run_mem(input vec_t v, input int gdly, input int rdly, input logic noise);
        int          stalls;
        logic [31:0] exp_addr;
        stalls   = 0;
        exp_addr = {v.addr[31:2], 2'b00};
        sb_q.push_back('{v.wen, v.waddr, v.wdata, 1'b0, 1'b0});
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        drive(v);
        #1;
        if (stall_req_o) stalls++;
        chk("req_at_accept", dbus_req_o, 0);
        step();
        for (int i = 0; i <= gdly; i++) begin
            dbus_gnt_i    = (i == gdly);
            dbus_rvalid_i = noise;
            dbus_rdata_i  = 32'h5555_AAAA;
            #1;
            chk("req_hold", dbus_req_o, 1);
            chk("bus_addr", dbus_addr_o, exp_addr);
            chk("bus_be", dbus_be_o, v.be);
            chk("bus_we", dbus_we_o, v.we);
            if (v.we) chk("bus_wdata", dbus_wdata_o, v.bwdata);
            if (stall_req_o) stalls++;
            step();
        end
        dbus_gnt_i = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            dbus_rvalid_i = (i == rdly);
            dbus_rdata_i  = (i == rdly) ? v.rdata : 32'hDEAD_DEAD;
            #1;
            chk("req_in_wait", dbus_req_o, 0);
            if (stall_req_o) stalls++;
            if (i == rdly) chk("stall_in_rvalid_cycle", stall_req_o, 0);
            step();
        end
        dbus_rvalid_i = 1'b0;
        valid_i       = 1'b0;
        check_wb();
        chk("stall_cycles", stalls, 2 + gdly + rdly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vt[0]  = '{0, EX_ADD_OP, 32'h0,     5'd5,  32'h0000_1234, 32'h0,         1'b0, 4'h0, 32'h0,         1'b1, 32'h0000_1234};
        vt[1]  = '{0, EX_ADD_OP, 32'h0,     5'd0,  32'h0000_1234, 32'h0,         1'b0, 4'h0, 32'h0,         1'b0, 32'h0};
        vt[2]  = '{1, EX_LB_OP,  32'h103,   5'd7,  32'h0,         32'h80FF_0000, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFFFF_FF80};
        vt[3]  = '{1, EX_LBU_OP, 32'h103,   5'd7,  32'h0,         32'h80FF_0000, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0000_0080};
        vt[4]  = '{1, EX_SH_OP,  32'h202,   5'd10, 32'hABCD_1234, 32'h0,         1'b1, 4'hC, 32'h1234_1234, 1'b0, 32'h0};
        vt[5]  = '{1, EX_SB_OP,  32'h101,   5'd10, 32'h1122_33A5, 32'h0,         1'b1, 4'h2, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vt[6]  = '{1, EX_SW_OP,  32'h300,   5'd10, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[7]  = '{1, EX_LH_OP,  32'h106,   5'd8,  32'h0,         32'h8001_7FFF, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFFFF_8001};
        vt[8]  = '{1, EX_LHU_OP, 32'h104,   5'd9,  32'h0,         32'h8001_F00D, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0000_F00D};
        vt[9]  = '{1, EX_LW_OP,  32'h10C,   5'd31, 32'h0,         32'h1234_5678, 1'b0, 4'hF, 32'h0,         1'b1, 32'h1234_5678};
        vt[10] = '{2, EX_LW_OP,  32'h102,   5'd6,  32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         1'b0, 32'h0};
        vt[11] = '{2, EX_SH_OP,  32'h201,   5'd6,  32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         1'b0, 32'h0};
        vt[12] = '{1, EX_LH_OP,  32'h102,   5'd11, 32'h0,         32'hBEEF_0000, 1'b0, 4'hF, 32'h0,         1'b1, 32'hFFFF_BEEF};
        vt[13] = '{1, EX_LB_OP,  32'h100,   5'd0,  32'h0,         32'h0000_007F, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0};
        vt[14] = '{1, EX_LB_OP,  32'h101,   5'd3,  32'h0,         32'h0000_7F00, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0000_007F};
        vt[15] = '{0, EX_OR_OP,  32'h0,     5'd12, 32'h0000_F0F0, 32'h0,         1'b0, 4'h0, 32'h0,         1'b1, 32'h0000_F0F0};
        vt[16] = '{1, EX_SB_OP,  32'h103,   5'd10, 32'h0000_005A, 32'h0,         1'b1, 4'h8, 32'h5A5A_5A5A, 1'b0, 32'h0};
        vt[17] = '{1, EX_LBU_OP, 32'h102,   5'd4,  32'h0,         32'h00C3_0000, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0000_00C3};
        vt[18] = '{2, EX_SW_OP,  32'h301,   5'd6,  32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         1'b0, 32'h0};

        rst_n         = 1'b0;
        valid_i       = 1'b0;
        aluop_i       = EX_NOP_OP;
        mem_addr_i    = '0;
        w_enable_i    = 1'b0;
        w_addr_i      = '0;
        w_data_i      = '0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = '0;
        #1;
        chk("reset_outputs_zero", outs_nonzero(), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", outs_nonzero(), 0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].kind == 1) run_mem(vt[i], 0, 0, 1'b0);
            else run_simple(vt[i]);
        end

        // LW with gnt delayed 3 cycles and rvalid 2 more; rvalid noise during REQ
        v = '{1, EX_LW_OP, 32'h208, 5'd13, 32'h0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D};
        run_mem(v, 3, 2, 1'b1);

        // Response timeout after 4 WAIT cycles
        v = '{1, EX_LW_OP, 32'h400, 5'd4, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0};
        sb_q.push_back('{1'b0, 5'd0, 32'h0, 1'b0, 1'b1});
        drive(v);
        #1;
        step();
        dbus_gnt_i = 1'b1;
        #1;
        chk("tmo_req", dbus_req_o, 1);
        step();
        dbus_gnt_i = 1'b0;
        valid_i    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_err_early", bus_err_o, 0);
            chk("tmo_stall", stall_req_o, 1);
            step();
        end
        check_wb();
        chk("tmo_idle_req", dbus_req_o, 0);
        chk("tmo_idle_stall", stall_req_o, 0);
        step();
        chk("tmo_err_one_cycle", bus_err_o, 0);
        run_simple(vt[0]);

        // Reset in WAIT, then stray rvalid/gnt after release
        v = '{1, EX_LW_OP, 32'h500, 5'd6, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0};
        drive(v);
        #1;
        step();
        dbus_gnt_i = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        valid_i    = 1'b0;
        #1;
        chk("wait_before_reset", stall_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs_nonzero(), 0);
        step();
        rst_n = 1'b1;
        step();
        dbus_rvalid_i = 1'b1;
        dbus_gnt_i    = 1'b1;
        dbus_rdata_i  = 32'h1357_9BDF;
        #1;
        chk("stray_no_req", dbus_req_o, 0);
        step();
        dbus_rvalid_i = 1'b0;
        dbus_gnt_i    = 1'b0;
        chk("stray_rvalid_dropped", outs_nonzero(), 0);
        v = '{0, EX_ADD_OP, 32'h0, 5'd8, 32'h0000_0055, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_0055};
        run_simple(v);
        run_mem(vt[9], 1, 1, 1'b0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
